// File: rtl/board_ctrl_pkg.sv
// Shared types and defaults for the board housekeeping block: reset FSM states,
// default cycle constants (50 MHz board clock), and the counter width helper.
// Latency: n/a (types only). Backpressure: n/a.
package board_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    QUAL = 2'd1,
    REL  = 2'd2,
    RUN  = 2'd3
  } rst_state_t;

  localparam int DEF_N_KEYS        = 4;
  localparam int DEF_DEBOUNCE_CYC  = 1_000_000;   // 20 ms
  localparam int DEF_N_RST         = 2;
  localparam int DEF_RST_STAGE_CYC = 1024;
  localparam int DEF_N_ACT         = 8;
  localparam int DEF_STRETCH_CYC   = 2_500_000;   // 50 ms
  localparam int DEF_HB_HALF_CYC   = 25_000_000;  // 1 Hz heartbeat

  // Bits needed to hold 0..max_cnt; never returns less than 1 so degenerate
  // parameter choices still produce a legal vector.
  function automatic int cnt_w(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/board_status_ctrl_key_debounce.sv
// Debounces one raw active-low push key: 2-FF sync, persistence counter, press pulse.
// Latency: key_db follows a stable level 2 sync cycles + DEBOUNCE_CYC cycles later.
// Backpressure: none; free-running, key_press is a single-cycle strobe.
// Ports: clk, reset (async, active-high), key_n (raw, async) ->
//        key_db (1 = pressed), key_press (one cycle on debounced press).
module key_debounce
  import board_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_db,
  output logic key_press
);

  localparam int CW = cnt_w(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  // Synchroniser carries the pressed level (inverted key) so its reset value
  // of 0 matches an idle, unpressed key.
  logic [1:0]    press_sync;
  logic          pressed;
  logic [CW-1:0] cnt;
  logic          key_db_q;

  assign pressed = press_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_sync <= 2'b00;
      cnt        <= '0;
      key_db     <= 1'b0;
      key_db_q   <= 1'b0;
    end else begin
      press_sync <= {press_sync[0], ~key_n};
      key_db_q   <= key_db;
      if (pressed == key_db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        key_db <= ~key_db;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign key_press = key_db & ~key_db_q;

endmodule

// File: rtl/board_status_ctrl.sv
// Board housekeeping: key debounce, staged reset release into N_RST domains, activity/heartbeat LEDs.
// Latency: resets release RST_STAGE_CYC apart after PLL qualification; LEDs/sys_ready registered 1 cycle.
// Backpressure: none; all outputs are levels or single-cycle strobes.
// Ports: clk, reset (async, active-high); key_n[N_KEYS], pll_locked, pcie_link_up (async inputs);
//        act_in[N_ACT] (clk domain strobes) -> key_db, key_press, rst_out[N_RST], sys_ready,
//        act_led[N_ACT], hb_led.
module board_status_ctrl
  import board_ctrl_pkg::*;
#(
  parameter int N_KEYS        = DEF_N_KEYS,
  parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int N_RST         = DEF_N_RST,
  parameter int RST_STAGE_CYC = DEF_RST_STAGE_CYC,
  parameter int N_ACT         = DEF_N_ACT,
  parameter int STRETCH_CYC   = DEF_STRETCH_CYC,
  parameter int HB_HALF_CYC   = DEF_HB_HALF_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  input  logic              pll_locked,
  input  logic              pcie_link_up,
  input  logic [N_ACT-1:0]  act_in,
  output logic [N_KEYS-1:0] key_db,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_RST-1:0]  rst_out,
  output logic              sys_ready,
  output logic [N_ACT-1:0]  act_led,
  output logic              hb_led
);

  localparam int STAGE_W = cnt_w(RST_STAGE_CYC - 1);
  localparam int IDX_W   = cnt_w(N_RST - 1);
  localparam int ACT_W   = cnt_w(STRETCH_CYC - 1);
  localparam int HB_W    = cnt_w(HB_HALF_CYC - 1);

  localparam logic [STAGE_W-1:0] STAGE_MAX   = STAGE_W'(RST_STAGE_CYC - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX     = IDX_W'(N_RST - 1);
  localparam logic [ACT_W-1:0]   STRETCH_MAX = ACT_W'(STRETCH_CYC - 1);
  localparam logic [HB_W-1:0]    HB_MAX      = HB_W'(HB_HALF_CYC - 1);

  // ---------------------------------------------------------------- keys
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_debounce (
      .clk       (clk),
      .reset     (reset),
      .key_n     (key_n[k]),
      .key_db    (key_db[k]),
      .key_press (key_press[k])
    );
  end

  // ------------------------------------------------------ status syncs
  logic [1:0] pll_sync;
  logic [1:0] pcie_sync;
  logic       pll_s;
  logic       pcie_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pll_sync  <= 2'b00;
      pcie_sync <= 2'b00;
    end else begin
      pll_sync  <= {pll_sync[0], pll_locked};
      pcie_sync <= {pcie_sync[0], pcie_link_up};
    end
  end

  assign pll_s  = pll_sync[1];
  assign pcie_s = pcie_sync[1];

  // ------------------------------------------------- reset sequencer
  // Losing lock or holding key 0 forces HOLD from any state and wins over a
  // release or transition scheduled for the same edge.
  rst_state_t         state;
  logic [STAGE_W-1:0] stage_cnt;
  logic [IDX_W-1:0]   stage_idx;
  logic               abort;

  assign abort = ~pll_s | key_db[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HOLD;
      rst_out   <= '1;
      stage_cnt <= '0;
      stage_idx <= '0;
      sys_ready <= 1'b0;
    end else if (abort) begin
      state     <= HOLD;
      rst_out   <= '1;
      stage_cnt <= '0;
      stage_idx <= '0;
      sys_ready <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          // Not aborting here means lock is present and key 0 is released.
          rst_out   <= '1;
          stage_cnt <= '0;
          stage_idx <= '0;
          sys_ready <= 1'b0;
          state     <= QUAL;
        end
        QUAL: begin
          sys_ready <= 1'b0;
          if (stage_cnt == STAGE_MAX) begin
            stage_cnt <= '0;
            stage_idx <= '0;
            state     <= REL;
          end else begin
            stage_cnt <= stage_cnt + 1'b1;
          end
        end
        REL: begin
          sys_ready <= 1'b0;
          if (stage_cnt == STAGE_MAX) begin
            stage_cnt          <= '0;
            rst_out[stage_idx] <= 1'b0;
            if (stage_idx == IDX_MAX) begin
              state <= RUN;
            end else begin
              stage_idx <= stage_idx + 1'b1;
            end
          end else begin
            stage_cnt <= stage_cnt + 1'b1;
          end
        end
        RUN: begin
          rst_out   <= '0;
          sys_ready <= pcie_s;
        end
        default: begin
          state   <= HOLD;
          rst_out <= '1;
        end
      endcase
    end
  end

  // --------------------------------------------------------- heartbeat
  // Gated by abort as well so the LED drops on the same edge the FSM leaves RUN.
  logic [HB_W-1:0] hb_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hb_cnt <= '0;
      hb_led <= 1'b0;
    end else if (state == RUN && !abort) begin
      if (hb_cnt == HB_MAX) begin
        hb_cnt <= '0;
        hb_led <= ~hb_led;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end else begin
      hb_cnt <= '0;
      hb_led <= 1'b0;
    end
  end

  // ---------------------------------------------------- activity stretch
  // Any strobe reloads the full stretch, so a burst keeps the LED lit until
  // STRETCH_CYC cycles after its last strobe.
  logic [ACT_W-1:0] act_cnt [N_ACT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ACT; i++) begin
        act_cnt[i] <= '0;
      end
      act_led <= '0;
    end else begin
      for (int i = 0; i < N_ACT; i++) begin
        if (act_in[i]) begin
          act_cnt[i] <= STRETCH_MAX;
        end else if (act_cnt[i] != '0) begin
          act_cnt[i] <= act_cnt[i] - 1'b1;
        end
        act_led[i] <= (act_cnt[i] != '0) | act_in[i];
      end
    end
  end

endmodule
